// File: rtl/snoop_pkg.sv
// Shared types and helpers for the snoop port.
// Also used by the snoopable FIFO for its entry width.
package snoop_pkg;

   localparam int SNOOP_DATA_W = 10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SNOOP   = 2'd1,
      S_BACKOFF = 2'd2,
      S_RESP    = 2'd3
   } snoop_state_t;

   // Smallest width that can hold v; never less than 1.
   function automatic int cnt_bits(input int v);
      int n;
      n = 1;
      while ((1 << n) <= v) n++;
      return n;
   endfunction

endpackage

// File: rtl/snoop_backoff_timer.sv
// Down-counter that paces re-snoops.
// Load sets the count; decrement runs to zero and holds there.
module snoop_backoff_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Load has priority; decrement stops at zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/snoop_requester.sv
// Snoop initiator: probes the FIFO, backs off and retries
// while the value is still queued, then reports hit status.
module snoop_requester
   import snoop_pkg::*;
#(
   parameter int DATA_W    = SNOOP_DATA_W,
   parameter int BACKOFF   = 4,
   parameter int MAX_RETRY = 7,
   parameter int RETRY_W   = cnt_bits(MAX_RETRY)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [DATA_W-1:0]  req_data,
   input  logic               req_valid,
   output logic               req_ready,
   output logic [DATA_W-1:0]  sdata,
   output logic               svalid,
   input  logic               smatch,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_hit,
   output logic [RETRY_W-1:0] rsp_retries,
   output logic               rsp_valid,
   input  logic               rsp_ready
);

   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   snoop_state_t       r_state;
   logic [DATA_W-1:0]  r_sdata;
   logic [RETRY_W-1:0] r_retry;
   logic [DATA_W-1:0]  r_rsp_data;
   logic               r_rsp_hit;
   logic [RETRY_W-1:0] r_rsp_retries;
   logic               w_bo_zero;

   generate
      if (BACKOFF > 0) begin : g_timer
         localparam int BO_W = cnt_bits(BACKOFF);
         localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF - 1);

         logic w_bo_load;
         logic w_bo_dec;

         // Arm the timer on every match that will be retried.
         assign w_bo_load = (r_state == S_SNOOP) && smatch &&
                            (r_retry != RETRY_MAX);
         assign w_bo_dec  = (r_state == S_BACKOFF);

         snoop_backoff_timer #(
            .W (BO_W)
         ) u_timer (
            .clk        (clk),
            .rstn       (rstn),
            .i_load     (w_bo_load),
            .i_load_val (BO_LOAD),
            .i_dec      (w_bo_dec),
            .o_zero     (w_bo_zero)
         );
      end else begin : g_no_timer
         assign w_bo_zero = 1'b1;
      end
   endgenerate

   // Request/snoop/backoff/response sequencing and data capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_sdata       <= '0;
         r_retry       <= '0;
         r_rsp_data    <= '0;
         r_rsp_hit     <= 1'b0;
         r_rsp_retries <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_sdata <= req_data;
                  r_retry <= '0;
                  r_state <= S_SNOOP;
               end
            end
            S_SNOOP: begin
               if (!smatch || (r_retry == RETRY_MAX)) begin
                  r_rsp_data    <= r_sdata;
                  r_rsp_hit     <= smatch;
                  r_rsp_retries <= r_retry;
                  r_state       <= S_RESP;
               end else begin
                  r_retry <= r_retry + RETRY_W'(1);
                  r_state <= (BACKOFF == 0) ? S_SNOOP : S_BACKOFF;
               end
            end
            S_BACKOFF: begin
               if (w_bo_zero) begin
                  r_state <= S_SNOOP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign svalid      = (r_state == S_SNOOP);
   assign rsp_valid   = (r_state == S_RESP);
   assign sdata       = r_sdata;
   assign rsp_data    = r_rsp_data;
   assign rsp_hit     = r_rsp_hit;
   assign rsp_retries = r_rsp_retries;

endmodule

// File: tb/tb_snoop_requester.sv
// Directed bench for snoop_requester: one instance with
// BACKOFF=4, one with BACKOFF=0 for back-to-back re-snoops.
module tb_snoop_requester;

   logic       clk;
   logic       rstn;

   logic [9:0] req_data;
   logic       req_valid;
   logic       req_ready;
   logic [9:0] sdata;
   logic       svalid;
   logic       smatch;
   logic [9:0] rsp_data;
   logic       rsp_hit;
   logic [2:0] rsp_retries;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       tb_match;

   logic [9:0] b_req_data;
   logic       b_req_valid;
   logic       b_req_ready;
   logic [9:0] b_sdata;
   logic       b_svalid;
   logic       b_smatch;
   logic [9:0] b_rsp_data;
   logic       b_rsp_hit;
   logic [2:0] b_rsp_retries;
   logic       b_rsp_valid;
   logic       b_rsp_ready;
   logic       b_tb_match;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // FIFO stand-in: match is combinational from the strobe.
   assign smatch   = svalid & tb_match;
   assign b_smatch = b_svalid & b_tb_match;

   snoop_requester #(
      .DATA_W (10), .BACKOFF (4), .MAX_RETRY (7), .RETRY_W (3)
   ) dut (
      .clk (clk), .rstn (rstn),
      .req_data (req_data), .req_valid (req_valid),
      .req_ready (req_ready),
      .sdata (sdata), .svalid (svalid), .smatch (smatch),
      .rsp_data (rsp_data), .rsp_hit (rsp_hit),
      .rsp_retries (rsp_retries), .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready)
   );

   snoop_requester #(
      .DATA_W (10), .BACKOFF (0), .MAX_RETRY (7), .RETRY_W (3)
   ) dut0 (
      .clk (clk), .rstn (rstn),
      .req_data (b_req_data), .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .sdata (b_sdata), .svalid (b_svalid), .smatch (b_smatch),
      .rsp_data (b_rsp_data), .rsp_hit (b_rsp_hit),
      .rsp_retries (b_rsp_retries), .rsp_valid (b_rsp_valid),
      .rsp_ready (b_rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a request for one edge; returns the accept edge index.
   task automatic send(input logic [9:0] d, output int t_acc);
      req_data  = d;
      req_valid = 1'b1;
      tick();
      t_acc     = cyc;
      req_valid = 1'b0;
   endtask

   // Walk to rsp_valid, answering the first match_n snoops with a hit.
   // Times are relative to the accept edge (first snoop cycle = 1).
   task automatic run(input int t_acc, input int match_n,
                      output int pulses, output int t1,
                      output int t2, output int t3, output int t_rsp);
      int to;
      pulses = 0; t1 = -1; t2 = -1; t3 = -1; t_rsp = -1;
      to = 0;
      while (!rsp_valid && to < 200) begin
         if (svalid) begin
            pulses++;
            if (pulses == 1) t1 = cyc - t_acc + 1;
            if (pulses == 2) t2 = cyc - t_acc + 1;
            if (pulses == 3) t3 = cyc - t_acc + 1;
            tb_match = (pulses <= match_n);
         end
         tick();
         to++;
      end
      if (rsp_valid) t_rsp = cyc - t_acc + 1;
      else chk("rsp_timeout", 32'd0, 32'd1);
      tb_match = 1'b0;
   endtask

   task automatic take();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hs_rsp_valid", rsp_valid, 1'b0);
      chk("hs_req_ready", req_ready, 1'b1);
   endtask

   initial begin
      int ta, np, t1, t2, t3, tr;
      rstn = 1'b0;
      req_data = '0; req_valid = 1'b0; rsp_ready = 1'b0;
      tb_match = 1'b0;
      b_req_data = '0; b_req_valid = 1'b0; b_rsp_ready = 1'b0;
      b_tb_match = 1'b0;
      tick(); tick();

      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_svalid", svalid, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_sdata", sdata, 10'h000);
      chk("rst_rsp", {rsp_data, rsp_hit, rsp_retries}, 14'h0);
      rstn = 1'b1;
      tick();

      // Reset in the middle of a snoop.
      send(10'h133, ta);
      chk("r1_svalid_pre", svalid, 1'b1);
      rstn = 1'b0;
      #1;
      chk("r1_svalid", svalid, 1'b0);
      chk("r1_rsp_valid", rsp_valid, 1'b0);
      chk("r1_req_ready", req_ready, 1'b1);
      tick();
      rstn = 1'b1;
      tick(); tick(); tick();
      chk("r1_no_rsp", rsp_valid, 1'b0);
      chk("r1_no_snoop", svalid, 1'b0);

      // No match: single snoop, response two cycles after accept.
      send(10'h2A1, ta);
      chk("nm_svalid_t1", svalid, 1'b1);
      chk("nm_sdata", sdata, 10'h2A1);
      chk("nm_req_ready", req_ready, 1'b0);
      tick();
      chk("nm_rsp_valid_t2", rsp_valid, 1'b1);
      chk("nm_svalid_off", svalid, 1'b0);
      chk("nm_rsp_data", rsp_data, 10'h2A1);
      chk("nm_rsp_hit", rsp_hit, 1'b0);
      chk("nm_retries", rsp_retries, 3'd0);
      take();

      // Two matching snoops then clear: snoops at 1, 6, 11.
      send(10'h0C3, ta);
      run(ta, 2, np, t1, t2, t3, tr);
      chk("cl_pulses", np, 3);
      chk("cl_t1", t1, 1);
      chk("cl_t2", t2, 6);
      chk("cl_t3", t3, 11);
      chk("cl_t_rsp", tr, 12);
      chk("cl_hit", rsp_hit, 1'b0);
      chk("cl_retries", rsp_retries, 3'd2);
      chk("cl_data", rsp_data, 10'h0C3);
      take();

      // Stuck match: give up after MAX_RETRY re-snoops.
      send(10'h3FF, ta);
      run(ta, 100, np, t1, t2, t3, tr);
      chk("gu_pulses", np, 8);
      chk("gu_t_rsp", tr, 37);
      chk("gu_hit", rsp_hit, 1'b1);
      chk("gu_retries", rsp_retries, 3'd7);
      chk("gu_data", rsp_data, 10'h3FF);
      take();

      // Backpressure with a competing request held high.
      send(10'h155, ta);
      tick();
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      req_data  = 10'h0F0;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", rsp_valid, 1'b1);
         chk("bp_hold_fields", {rsp_data, rsp_hit, rsp_retries},
             {10'h155, 1'b0, 3'd0});
         chk("bp_req_ready", req_ready, 1'b0);
         chk("bp_no_snoop", svalid, 1'b0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_hs_rsp_valid", rsp_valid, 1'b0);
      chk("bp_hs_idle", req_ready, 1'b1);
      chk("bp_hs_not_taken", svalid, 1'b0);
      tick();
      req_valid = 1'b0;
      chk("bp_second_snoop", svalid, 1'b1);
      chk("bp_second_sdata", sdata, 10'h0F0);
      tick();
      chk("bp_second_rsp", rsp_data, 10'h0F0);
      chk("bp_second_valid", rsp_valid, 1'b1);
      take();

      // Zero backoff: match then clear gives back-to-back snoops.
      b_tb_match  = 1'b1;
      b_req_data  = 10'h2B4;
      b_req_valid = 1'b1;
      tick();
      b_req_valid = 1'b0;
      chk("b0_svalid_1", b_svalid, 1'b1);
      chk("b0_sdata", b_sdata, 10'h2B4);
      tick();
      chk("b0_svalid_2", b_svalid, 1'b1);
      b_tb_match = 1'b0;
      tick();
      chk("b0_svalid_off", b_svalid, 1'b0);
      chk("b0_rsp_valid", b_rsp_valid, 1'b1);
      chk("b0_hit", b_rsp_hit, 1'b0);
      chk("b0_retries", b_rsp_retries, 3'd1);
      chk("b0_data", b_rsp_data, 10'h2B4);
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
      chk("b0_hs", b_rsp_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
